// File: rtl/dmem_io_param.sv
// dmem_io_param: parameterised single-port data memory with memory-mapped 7-segment digits and debounced switches.
// Optional sticky bounds-error output `err` is built when DMEM_IO_BOUNDS_ERR_EN is defined.
module dmem_io_param #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 128,
  parameter logic [WIDTH-1:0] IO_BASE = 16'hFFF0,
  parameter int              NUM_SW   = 2,
  parameter int              NUM_DISP = 1,
  parameter int              DEBOUNCE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  write,
  input  logic                  read,
  input  logic [NUM_SW-1:0]     sw,
  output logic [WIDTH-1:0]      rdata,
  output logic [7*NUM_DISP-1:0] disp_seg
`ifdef DMEM_IO_BOUNDS_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  // Bus strobes: read and write are single-cycle level strobes with no
  // backpressure; an access is taken on every rising edge it is high, rdata is
  // valid the cycle after a read edge and holds until the next read edge.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [3:0]       disp_q [NUM_DISP];

  logic [NUM_SW-1:0] sync1, sync2, sw_db, chg, accept;
  logic [CW-1:0]     cnt [NUM_SW];

  logic [WIDTH-1:0] io_off;
  logic [AW-1:0]    ram_idx;
  logic             is_ram, is_io, is_disp, is_status, is_flags, mapped;
  logic [3:0]       disp_rd;
  logic [WIDTH-1:0] rd_next;
  logic             clr_flags;

  // Offset is taken only after the base compare, so IO_BASE+15 at the top of
  // the address space never wraps.
  always_comb begin
    io_off    = addr - IO_BASE;
    is_ram    = addr < DEPTH_W;
    is_io     = (addr >= IO_BASE) && (io_off < WIDTH'(16));
    is_disp   = is_io && (io_off < WIDTH'(NUM_DISP));
    is_status = is_io && (io_off == WIDTH'(8));
    is_flags  = is_io && (io_off == WIDTH'(9));
    mapped    = is_ram | is_disp | is_status | is_flags;
    ram_idx   = addr[AW-1:0];
    clr_flags = read && is_flags;
  end

  always_comb begin
    disp_rd = '0;
    for (int k = 0; k < NUM_DISP; k++) begin
      if (io_off[2:0] == 3'(k)) disp_rd = disp_q[k];
    end
  end

  always_comb begin
    rd_next = '0;
    if (is_ram)         rd_next = mem[ram_idx];
    else if (is_disp)   rd_next = WIDTH'(disp_rd);
    else if (is_status) rd_next = WIDTH'(sw_db);
    else if (is_flags)  rd_next = WIDTH'(chg);
  end

  // RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && write && is_ram) mem[ram_idx] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
      for (int k = 0; k < NUM_DISP; k++) disp_q[k] <= '0;
    end else begin
      if (read) rdata <= rd_next;
      for (int k = 0; k < NUM_DISP; k++) begin
        if (write && is_disp && (io_off[2:0] == 3'(k))) disp_q[k] <= wdata[3:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SW; i++) begin
      accept[i] = (sync2[i] != sw_db[i]) && (cnt[i] == CW'(DEBOUNCE - 1));
    end
  end

  // A flag raised on the same edge as a clearing read wins over the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sw_db <= '0;
      chg   <= '0;
      for (int i = 0; i < NUM_SW; i++) cnt[i] <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2[i] != sw_db[i]) begin
          if (accept[i]) begin
            sw_db[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
      chg <= (clr_flags ? '0 : chg) | accept;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    disp_seg = '0;
    for (int k = 0; k < NUM_DISP; k++) disp_seg[7*k +: 7] = hex7(disp_q[k]);
  end

`ifdef DMEM_IO_BOUNDS_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (((read || write) && !mapped) || (write && (is_status || is_flags))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/dmem_io_param.md
Name: dmem_io_param

Overview:
- Parametrised successor to the single-port data memory with memory-mapped I/O used by the 16-bit processor.
- Adds configurable word width, RAM depth, switch count and 7-segment digit count.
- Adds registered read with fixed latency, debounced switch inputs with sticky change flags, and hex-to-7-segment decode per digit.
- Sits between the processor data-memory port (addr/wdata/write/read) and the board I/O.

Parameters:
WIDTH, 16, data and address word width in bits
DEPTH, 128, RAM words, addresses 0..DEPTH-1; power of two, at most IO_BASE
IO_BASE, 16'hFFF0, first I/O address; I/O window is IO_BASE..IO_BASE+15
NUM_SW, 2, number of switch inputs, 1..WIDTH
NUM_DISP, 1, number of 7-segment digits, 1..8
DEBOUNCE, 4, consecutive stable synchronised samples required to accept a switch change, at least 1

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
addr  in  WIDTH  word address
wdata  in  WIDTH  write data
write  in  1  write enable
read  in  1  read enable
sw  in  NUM_SW  raw asynchronous switch inputs
rdata  out  WIDTH  registered read data
disp_seg  out  7*NUM_DISP  active-low segments {g..a}; digit k occupies bits [7k+6:7k]

Behaviour:
- Reset, synchronous, active-high:
  - rdata=0; all display registers=0, so each digit shows 7'b1000000 ("0").
  - Debounced switch state and synchroniser flops = 0; change flags = 0; debounce counters = 0.
  - RAM contents are not reset.
- Address map:
  - 0..DEPTH-1: RAM.
  - IO_BASE+k, k<NUM_DISP: display register k (R/W; low 4 bits used, upper bits read 0).
  - IO_BASE+8: switch status (RO; bit i = debounced sw[i], upper bits 0).
  - IO_BASE+9: change flags (read clears).
  - Any other address: unmapped. Writes are ignored and reads return 0.
- Writes: committed on the rising edge where write=1. Writes to IO_BASE+8 and IO_BASE+9 are ignored.
- Reads:
  - rdata is updated on the edge where read=1 and is valid the cycle after (latency 1).
  - rdata holds its value while read=0.
  - Read and write to the same address in the same cycle returns the old data (read-before-write).
- read and write both high: both are performed.
- Switch path:
  - 2-flop synchroniser per bit, then a per-bit counter.
  - The counter increments while the synchronised value differs from the debounced value and clears otherwise.
  - When the counter reaches DEBOUNCE, the debounced bit takes the new value, its change flag is set, and the counter clears.
  - Total latency from a stable sw edge to the updated status bit = 2 + DEBOUNCE cycles.
- Change flags:
  - Sticky; cleared by a read of IO_BASE+9, effective on that edge.
  - A debounced edge in the same cycle as a clearing read leaves that flag set. The read returns the pre-clear value.
- Display:
  - Combinational hex decode of each 4-bit display register to active-low segments: 0-9, A, b, C, d, E, F.
  - disp_seg changes in the cycle after the write edge.
- Address width: addr is compared at full WIDTH; RAM index uses the low log2(DEPTH) bits only after the range check.

Optional Feature:
- Macro: DMEM_IO_BOUNDS_ERR_EN.
- When defined:
  - Adds output port err (1 bit).
  - err is set on any read or write to an unmapped address, or a write to read-only I/O.
  - err is sticky until reset; reset value 0; it asserts the cycle after the offending access.
- When undefined: no err port; offending accesses are silently ignored or return 0 as above.

Test Plan:
- reset; write addr 5 = 16'h00A3; read addr 5 -> rdata=16'h00A3 exactly one cycle after the read edge, 0 before.
- Same-cycle write addr 5 = 16'h1234 and read addr 5 (holding 16'h00A3) -> rdata=16'h00A3; next read -> 16'h1234.
- Write IO_BASE+0 = 16'h0007 -> disp_seg[6:0]=7'b1111000 next cycle; read IO_BASE+0 -> 16'h0007. Reset -> disp_seg[6:0]=7'b1000000.
- sw[0] 0->1 with 1-cycle glitches, then held stable -> status bit0=1 exactly 2+DEBOUNCE=6 cycles after the stable edge. Glitches shorter than 4 cycles cause no change.
- After the sw[0] edge, read IO_BASE+9 -> 16'h0001, next read -> 16'h0000. Edge coinciding with the clearing read -> next read returns 16'h0001.
- With DMEM_IO_BOUNDS_ERR_EN: read addr 16'h0200 -> rdata=0, err=1 next cycle and stays 1 until reset. Write IO_BASE+8 -> err=1 and status unchanged.
